// File: rtl/sel8_pkg.sv
// Shared widths and FSM state encoding for the sel8_scan block.
package sel8_pkg;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sel8_prescaler.sv
// Step-tick generator: while enabled, pulses tick once every DIV cycles.
// Counter restarts from zero on clear so every scan step is a full DIV long.
module sel8_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  // Explicit wrap on tick keeps non-power-of-two divisors exact.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/sel8_scan.sv
// Captures a word on start and walks sel 0..7 over it with EN high, then pulses done.
// Optional macro SEL8_SCAN_PRESCALE_EN stretches each step to PRESCALE_DIV cycles.
module sel8_scan
  import sel8_pkg::*;
#(
  parameter int PRESCALE_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] word_out,
  output logic [SEL_W-1:0]  sel,
  output logic              EN,
  output logic              busy,
  output logic              done
);
  state_t state;
  logic   step;

  if (PRESCALE_DIV < 2 || PRESCALE_DIV > 16) begin : g_bad_div
    $error("sel8_scan: PRESCALE_DIV must be within 2..16");
  end

`ifdef SEL8_SCAN_PRESCALE_EN
  logic pre_clear;

  assign pre_clear = ((state == IDLE) && start && !stop) || ((state == SCAN) && stop);

  sel8_prescaler #(
    .DIV (PRESCALE_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (pre_clear),
    .en    (state == SCAN),
    .tick  (step)
  );
`else
  assign step = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_out <= '0;
      sel      <= '0;
      EN       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // stop dominates a simultaneous start
          if (start && !stop) begin
            word_out <= data_in;
            sel      <= '0;
            EN       <= 1'b1;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (stop) begin
            sel   <= '0;
            EN    <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (step) begin
            if (sel == {SEL_W{1'b1}}) begin
              sel   <= '0;
              EN    <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              sel <= sel + SEL_W'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          sel   <= '0;
          EN    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sel8_scan.sv
// Bench for sel8_scan: directed vector table, corner sequences, then random traffic vs a cycle-count model.
module tb_sel8_scan;
  localparam int PDIV = 4;
`ifdef SEL8_SCAN_PRESCALE_EN
  localparam int STEP = PDIV;
`else
  localparam int STEP = 1;
`endif
  localparam int SCAN_LEN = 8 * STEP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] word_out;
  logic [2:0] sel;
  logic       EN;
  logic       busy;
  logic       done;

  sel8_scan #(.PRESCALE_DIV(PDIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .data_in  (data_in),
    .word_out (word_out),
    .sel      (sel),
    .EN       (EN),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: m_t = -1 idle, 0..SCAN_LEN-1 cycles into a scan, SCAN_LEN the done cycle.
  int         m_t = -1;
  logic [7:0] m_word = 8'h00;

  typedef struct {
    logic       start;
    logic [7:0] din;
    logic [2:0] sel;
    logic       en;
    logic       busy;
    logic       done;
    logic [7:0] word;
    logic       mux;
  } vec_t;

  vec_t vt[$];
  int   mux_seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic p, input logic [7:0] d);
    if (r) begin
      m_t = -1;
      m_word = 8'h00;
    end else if (m_t < 0) begin
      if (s && !p) begin
        m_t = 0;
        m_word = d;
      end
    end else if (m_t < SCAN_LEN) begin
      if (p) m_t = -1;
      else m_t = m_t + 1;
    end else begin
      m_t = -1;
    end
  endtask

  task automatic check_model();
    logic scanning;
    scanning = (m_t >= 0) && (m_t < SCAN_LEN);
    chk("model_sel", 32'(sel), scanning ? 32'(m_t / STEP) : 32'd0);
    chk("model_en", 32'(EN), 32'(scanning));
    chk("model_busy", 32'(busy), 32'(scanning));
    chk("model_done", 32'(done), 32'(m_t == SCAN_LEN));
    chk("model_word", 32'(word_out), 32'(m_word));
  endtask

  task automatic cyc(input logic r, input logic s, input logic p, input logic [7:0] d);
    rst = r;
    start = s;
    stop = p;
    data_in = d;
    @(posedge clk);
    model_step(r, s, p, d);
    #1;
    check_model();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int dones;
    vec_t v;

    // Reset state
    cyc(1, 0, 0, 8'h00);
    cyc(1, 1, 0, 8'hEE);
    chk("rst_word", 32'(word_out), 32'h00);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_en", 32'(EN), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // A5 scan with data change and start re-pulse mid-scan
    for (int j = 0; j <= SCAN_LEN + 1; j++) begin
      v.start = (j == 0) || (j == 4);
      v.din   = (j < 4) ? 8'hA5 : 8'h3C;
      v.en    = (j < SCAN_LEN);
      v.busy  = (j < SCAN_LEN);
      v.sel   = (j < SCAN_LEN) ? 3'(j / STEP) : 3'd0;
      v.done  = (j == SCAN_LEN);
      v.word  = 8'hA5;
      v.mux   = (j < SCAN_LEN) ? 1'(mux_seq[j / STEP]) : 1'b0;
      vt.push_back(v);
    end
    foreach (vt[i]) begin
      cyc(0, vt[i].start, 0, vt[i].din);
      chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(vt[i].sel));
      chk($sformatf("tbl%0d_en", i), 32'(EN), 32'(vt[i].en));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vt[i].busy));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(vt[i].done));
      chk($sformatf("tbl%0d_word", i), 32'(word_out), 32'(vt[i].word));
      chk($sformatf("tbl%0d_mux", i), 32'(EN & word_out[sel]), 32'(vt[i].mux));
    end

    // Stop while sel=3
    cyc(0, 1, 0, 8'h5A);
    n = 0;
    while (sel != 3'd3 && n < 64) begin
      cyc(0, 0, 0, 8'h00);
      n++;
    end
    chk("stop_reach_sel3", 32'(sel), 32'd3);
    cyc(0, 0, 1, 8'h00);
    chk("stop_en", 32'(EN), 32'd0);
    chk("stop_sel", 32'(sel), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    dones = 0;
    for (int i = 0; i < SCAN_LEN + 2; i++) begin
      cyc(0, 0, 0, 8'h00);
      dones += int'(done);
    end
    chk("stop_no_done", 32'(dones), 32'd0);

    // Later start scans normally
    cyc(0, 1, 0, 8'hC3);
    dones = 0;
    for (int i = 0; i < SCAN_LEN + 2; i++) begin
      cyc(0, 0, 0, 8'h00);
      dones += int'(done);
    end
    chk("restart_done_count", 32'(dones), 32'd1);
    chk("restart_word", 32'(word_out), 32'hC3);

    // Reset while sel=5, with start also high
    cyc(0, 1, 0, 8'h96);
    n = 0;
    while (sel != 3'd5 && n < 64) begin
      cyc(0, 0, 0, 8'h00);
      n++;
    end
    chk("rst_reach_sel5", 32'(sel), 32'd5);
    cyc(1, 1, 0, 8'h11);
    chk("midrst_word", 32'(word_out), 32'h00);
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_en", 32'(EN), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    // First edge after reset release accepts start
    cyc(0, 1, 0, 8'h77);
    chk("post_rst_busy", 32'(busy), 32'd1);
    chk("post_rst_word", 32'(word_out), 32'h77);
    for (int i = 0; i < SCAN_LEN + 1; i++) cyc(0, 0, 0, 8'h00);

    // start and stop together in IDLE
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 8'hFF);
      chk("startstop_busy", 32'(busy), 32'd0);
      chk("startstop_en", 32'(EN), 32'd0);
      chk("startstop_word", 32'(word_out), 32'h77);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 15) == 0), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sel8_scan.md
SEL8_SCAN -- requirements
Module: sel8_scan

Interface
REQ-001 SHALL provide parameter PRESCALE_DIV, default 4, meaning clock cycles per select step when the prescaler is compiled in; legal range 2..16.
REQ-002 SHALL provide port clk  input  1  the single rising-edge clock.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port start  input  1  scan request, sampled in IDLE only.
REQ-005 SHALL provide port stop  input  1  abort request, sampled in SCAN.
REQ-006 SHALL provide port data_in  input  8  word captured on an accepted start.
REQ-007 SHALL provide port word_out  output  8  held word, driving the downstream SEL8 in bus.
REQ-008 SHALL provide port sel  output  3  select index, driving SEL8 sel.
REQ-009 SHALL provide port EN  output  1  enable, driving SEL8 EN; high only in SCAN.
REQ-010 SHALL provide port busy  output  1  high while in SCAN.
REQ-011 SHALL provide port done  output  1  one-cycle pulse on normal scan completion.

Function
REQ-012 SHALL implement an FSM with the states IDLE, SCAN and DONE.
REQ-013 IDLE: start=1 and stop=0 at an edge SHALL capture data_in into word_out, set sel=0, EN=1, busy=1, and enter SCAN.
REQ-014 SCAN: each sel value SHALL be held for one step (1 cycle, or PRESCALE_DIV cycles per REQ-024), after which sel SHALL increment by 1.
REQ-015 At the end of the sel=7 step, the FSM SHALL enter DONE, with sel=0, EN=0, busy=0 and done=1 for exactly one cycle, then return to IDLE.
REQ-016 Latency without the prescaler: start accepted at edge k gives sel=i during cycle k+1+i (i=0..7), and done=1 during cycle k+9.
REQ-017 sel SHALL NOT wrap 7->0 while EN=1; every scan covers exactly 8 steps.
REQ-018 word_out SHALL hold its value through SCAN, DONE and IDLE until the next accepted start; data_in changes during SCAN SHALL be ignored.
REQ-019 start SHALL be ignored in SCAN and in DONE.
REQ-020 stop=1 in SCAN SHALL cause entry to IDLE at the next edge, with EN=0, sel=0, busy=0 and no done pulse.
REQ-021 start and stop both high in IDLE SHALL leave the FSM in IDLE (stop wins).

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, word_out=8'h00, sel=0, EN=0, busy=0, done=0, and prescale count=0, overriding all other inputs including mid-scan.
REQ-023 The first start SHALL be accepted at the first edge after rst is deasserted.

Configuration
REQ-024 When macro SEL8_SCAN_PRESCALE_EN is defined, each step SHALL last PRESCALE_DIV cycles; the prescale counter SHALL clear on an accepted start and on stop. done SHALL then occur during cycle k+1+8*PRESCALE_DIV.
REQ-025 When SEL8_SCAN_PRESCALE_EN is undefined, each step SHALL last 1 cycle, PRESCALE_DIV SHALL be ignored, and no prescaler logic SHALL be present.

Structure
REQ-026 Shared package sel8_pkg SHALL hold SEL_W=3, DATA_W=8 and the FSM state typedef (IDLE, SCAN, DONE).
REQ-027 The prescaler SHALL be sub-module sel8_prescaler, which emits a one-cycle step tick and is instantiated only under SEL8_SCAN_PRESCALE_EN.

Verification
REQ-028 Macro off: reset, then data_in=8'hA5 with start pulse at edge k -> sel 0..7 on cycles k+1..k+8, EN=1 throughout, SEL8 out sequence 1,0,1,0,0,1,0,1, and done=1 only on cycle k+9.
REQ-029 data_in changed to 8'h3C and start re-pulsed at cycle k+4 -> word_out stays 8'hA5 and the timing is unchanged.
REQ-030 stop=1 while sel=3 -> next cycle EN=0, sel=0, busy=0, and no done pulse; a later start scans normally.
REQ-031 rst=1 while sel=5 -> next cycle all outputs are zero, including word_out=8'h00.
REQ-032 start=1 and stop=1 together in IDLE -> busy stays 0 and EN stays 0.
REQ-033 Macro on, PRESCALE_DIV=4: start at edge k -> each sel value held 4 cycles, and done=1 on cycle k+33.
